// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer
//   Brings up the PLL from its reference clock and holds the PLL-clocked user
//   logic in reset until the PLL reports a steady lock. Loss of lock while
//   running drops the downstream reset, re-arms the steady-lock detector and
//   starts over. Attempts that time out are retried a limited number of times
//   before a sticky fault is raised.
//
//   Ports
//     clk            PLL reference clock
//     rst            asynchronous, active-low reset
//     pll_lock       raw PLL lock (asynchronous)
//     pll_lock_stdy  raw PLL steady-lock (asynchronous)
//     lock_stdy_rst  re-arm pulse for the steady-lock detector
//     dut_rst        active-low reset for PLL-domain logic (1 = run)
//     run            high while in RUN
//     fault          sticky failure flag
//     retry_cnt      timed-out attempts in the current bring-up
//     loss_cnt       lock-loss events since reset, saturating at 255
//     state          FSM state encoding for on-chip debug
//     led            status LED
//
//   Every output comes straight from a flop. Output flops are loaded from the
//   next-state value, so each one changes on the same edge as the state.
module pll_rst_sequencer #(
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int REARM_CYCLES  = 16,
  parameter int MAX_RETRY     = 3,
  parameter int BLINK_DIV     = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       pll_lock_stdy,
  output logic       lock_stdy_rst,
  output logic       dut_rst,
  output logic       run,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state,
  output logic       led
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REARM     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_LOST      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  // The shared timer must reach the largest of the three intervals.
  localparam int T_MAX_A = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int T_MAX   = (T_MAX_A > REARM_CYCLES) ? T_MAX_A : REARM_CYCLES;
  localparam int TW      = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_REARM_END  = TW'(REARM_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK_END   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SETTLE_END = TW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  // Two-flop synchronisers for the asynchronous lock indications.
  logic lock_meta_q, lock_s_q;
  logic stdy_meta_q, stdy_s_q;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [1:0]            retry_cnt_q, retry_cnt_d;
  logic [7:0]            loss_cnt_q, loss_cnt_d;
  logic [BLINK_DIV-1:0]  presc_q, presc_d;
  logic                  lock_stdy_rst_q, lock_stdy_rst_d;
  logic                  dut_rst_q, dut_rst_d;
  logic                  run_q, run_d;
  logic                  fault_q, fault_d;
  logic                  led_q, led_d;

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    case (state_q)
      ST_IDLE: state_d = ST_REARM;

      ST_REARM: begin
        if (timer_q == T_REARM_END) state_d = ST_WAIT_LOCK;
      end

      // A lock seen on the timeout cycle still wins.
      ST_WAIT_LOCK: begin
        if (lock_s_q && stdy_s_q) begin
          state_d = ST_SETTLE;
        end else if (timer_q == T_LOCK_END) begin
          if (retry_cnt_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_cnt_d = retry_cnt_q + 2'd1;
            state_d     = ST_REARM;
          end
        end
      end

      ST_SETTLE: begin
        if (!lock_s_q)                      state_d = ST_WAIT_LOCK;
        else if (timer_q == T_SETTLE_END)   state_d = ST_RUN;
      end

      // Loss bookkeeping is loaded on entry to LOST so the counters change on
      // the same edge that drops dut_rst.
      ST_RUN: begin
        if (!lock_s_q || !stdy_s_q) begin
          state_d     = ST_LOST;
          retry_cnt_d = 2'd0;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end
      end

      ST_LOST:  state_d = ST_REARM;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change, including SETTLE -> WAIT_LOCK,
    // which gives a fresh lock timeout after a glitch.
    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    presc_d = presc_q + BLINK_DIV'(1);

    lock_stdy_rst_d = (state_d == ST_REARM);
    dut_rst_d       = (state_d == ST_RUN);
    run_d           = (state_d == ST_RUN);
    fault_d         = (state_d == ST_FAULT);

    case (state_d)
      ST_WAIT_LOCK, ST_SETTLE: led_d = presc_d[BLINK_DIV-3];
      ST_RUN:                  led_d = presc_d[BLINK_DIV-1];
      ST_FAULT:                led_d = 1'b1;
      default:                 led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_meta_q     <= 1'b0;
      lock_s_q        <= 1'b0;
      stdy_meta_q     <= 1'b0;
      stdy_s_q        <= 1'b0;
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      retry_cnt_q     <= 2'd0;
      loss_cnt_q      <= 8'd0;
      presc_q         <= '0;
      lock_stdy_rst_q <= 1'b0;
      dut_rst_q       <= 1'b0;
      run_q           <= 1'b0;
      fault_q         <= 1'b0;
      led_q           <= 1'b0;
    end else begin
      lock_meta_q     <= pll_lock;
      lock_s_q        <= lock_meta_q;
      stdy_meta_q     <= pll_lock_stdy;
      stdy_s_q        <= stdy_meta_q;
      state_q         <= state_d;
      timer_q         <= timer_d;
      retry_cnt_q     <= retry_cnt_d;
      loss_cnt_q      <= loss_cnt_d;
      presc_q         <= presc_d;
      lock_stdy_rst_q <= lock_stdy_rst_d;
      dut_rst_q       <= dut_rst_d;
      run_q           <= run_d;
      fault_q         <= fault_d;
      led_q           <= led_d;
    end
  end

  assign lock_stdy_rst = lock_stdy_rst_q;
  assign dut_rst       = dut_rst_q;
  assign run           = run_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_cnt_q;
  assign loss_cnt      = loss_cnt_q;
  assign state         = state_q;
  assign led           = led_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Testbench for pll_rst_sequencer. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, so "step i" means i rising edges
// after the stimulus point. Expected cycle numbers come from the bring-up
// rules: attempt k has its re-arm pulse on steps 1+k*P..REARM+k*P and waits
// for lock on the following LOCK_TIMEOUT steps (P = REARM + LOCK_TIMEOUT);
// a lock edge is visible to the FSM two edges after it is driven.
module tb_pll_rst_sequencer;

  localparam int LOCK_TIMEOUT  = 50;
  localparam int SETTLE_CYCLES = 8;
  localparam int REARM_CYCLES  = 4;
  localparam int MAX_RETRY     = 2;
  localparam int BLINK_DIV     = 6;
  localparam int PERIOD        = REARM_CYCLES + LOCK_TIMEOUT;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       pll_lock;
  logic       pll_lock_stdy;
  logic       lock_stdy_rst;
  logic       dut_rst;
  logic       run;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;
  logic       led;

  int          n_tests;
  int          n_fail;
  int unsigned cyc;       // rising edges since reset release (LED prescaler model)
  int          exp_loss;
  logic [7:0]  exp_q[$];

  pll_rst_sequencer #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .REARM_CYCLES (REARM_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .BLINK_DIV    (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .pll_lock_stdy(pll_lock_stdy),
    .lock_stdy_rst(lock_stdy_rst),
    .dut_rst      (dut_rst),
    .run          (run),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .loss_cnt     (loss_cnt),
    .state        (state),
    .led          (led)
  );

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; pll_lock = 1'b0; pll_lock_stdy = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({lock_stdy_rst, dut_rst, run, fault, retry_cnt, loss_cnt, state, led} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {lock_stdy_rst, dut_rst, run, fault, retry_cnt, loss_cnt, state, led});
    end
    exp_loss = 0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  // Locks rise after step r; checks the re-arm pulses, exact RUN edge and retry count.
  task automatic test_bringup(input int r);
    int s, e_set, run_e, retries, ws, we;
    bit found, exp_lsr, exp_dr;
    s = r + 2; found = 0; e_set = 0; retries = 0;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      ws = 1 + REARM_CYCLES + k * PERIOD;
      we = REARM_CYCLES + LOCK_TIMEOUT + k * PERIOD;
      if (!found && s <= we) begin
        e_set = ((s > ws) ? s : ws) + 1;
        retries = k;
        found = 1;
      end
    end
    run_e = e_set + SETTLE_CYCLES;
    for (int i = 1; i <= run_e; i++) begin
      @(negedge clk);
      exp_lsr = (i < e_set) && (((i - 1) % PERIOD) < REARM_CYCLES);
      exp_dr  = (i >= run_e);
      n_tests++;
      if (lock_stdy_rst !== exp_lsr) begin
        n_fail++;
        $display("FAIL bringup_lock_stdy_rst r=%0d step=%0d: got %b expected %b", r, i, lock_stdy_rst, exp_lsr);
      end
      n_tests++;
      if (dut_rst !== exp_dr) begin
        n_fail++;
        $display("FAIL bringup_dut_rst r=%0d step=%0d: got %b expected %b", r, i, dut_rst, exp_dr);
      end
      if (i == r) begin pll_lock = 1'b1; pll_lock_stdy = 1'b1; end
    end
    n_tests++;
    if ({run, fault, state, retry_cnt} !== {1'b1, 1'b0, 3'd4, 2'(retries)}) begin
      n_fail++;
      $display("FAIL bringup_run r=%0d: got run=%b fault=%b state=%0d retry=%0d expected run=1 fault=0 state=4 retry=%0d",
               r, run, fault, state, retry_cnt, retries);
    end
  endtask

  // Lock never arrives: three pulses, then a sticky fault.
  task automatic test_no_lock();
    int fault_e, pulses;
    bit prev, exp_lsr, exp_led, exp_fault;
    fault_e = 1 + (MAX_RETRY + 1) * PERIOD;
    pulses = 0; prev = 0;
    for (int i = 1; i <= fault_e + 20; i++) begin
      @(negedge clk);
      exp_lsr   = (i < fault_e) && (((i - 1) % PERIOD) < REARM_CYCLES);
      exp_fault = (i >= fault_e);
      if (i >= fault_e)                               exp_led = 1'b1;
      else if (((i - 1) % PERIOD) < REARM_CYCLES)     exp_led = 1'b0;
      else                                            exp_led = cyc[BLINK_DIV-3];
      n_tests++;
      if ({lock_stdy_rst, fault, dut_rst, led} !== {exp_lsr, exp_fault, 1'b0, exp_led}) begin
        n_fail++;
        $display("FAIL no_lock step=%0d: got lsr=%b fault=%b dut_rst=%b led=%b expected %b %b 0 %b",
                 i, lock_stdy_rst, fault, dut_rst, led, exp_lsr, exp_fault, exp_led);
      end
      if (lock_stdy_rst && !prev) pulses++;
      prev = lock_stdy_rst;
      if (i == fault_e) begin
        n_tests++;
        if ({state, retry_cnt} !== {3'd6, 2'(MAX_RETRY)}) begin
          n_fail++;
          $display("FAIL no_lock_fault_state: got state=%0d retry=%0d expected state=6 retry=%0d",
                   state, retry_cnt, MAX_RETRY);
        end
      end
    end
    n_tests++;
    if (pulses != MAX_RETRY + 1) begin
      n_fail++;
      $display("FAIL no_lock_pulses: got %0d expected %0d", pulses, MAX_RETRY + 1);
    end
  endtask

  // One-cycle pll_lock glitch g steps into SETTLE: back to WAIT_LOCK, fresh settle.
  task automatic test_settle_glitch(input int g);
    int r, e_set, d, run_e;
    r = $urandom_range(3, 30);
    e_set = r + 3;
    d = e_set + g;
    run_e = d + 12;
    for (int i = 1; i <= run_e; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_rst !== (i >= run_e)) begin
        n_fail++;
        $display("FAIL glitch_dut_rst g=%0d step=%0d: got %b expected %b", g, i, dut_rst, (i >= run_e));
      end
      if (i == d + 3) begin
        n_tests++;
        if (state !== 3'd2) begin
          n_fail++;
          $display("FAIL glitch_wait_lock g=%0d: got state=%0d expected 2", g, state);
        end
      end
      if (i == d + 4) begin
        n_tests++;
        if (state !== 3'd3) begin
          n_fail++;
          $display("FAIL glitch_resettle g=%0d: got state=%0d expected 3", g, state);
        end
      end
      if (i == r)     begin pll_lock = 1'b1; pll_lock_stdy = 1'b1; end
      if (i == d)     pll_lock = 1'b0;
      if (i == d + 1) pll_lock = 1'b1;
    end
    n_tests++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_run g=%0d: got %b expected 1", g, run);
    end
  endtask

  // From RUN: drop lock (kind 0), steady lock (1) or both (2), then relock.
  task automatic test_lock_loss(input int kind);
    int r_up, e_set, w, run_e;
    logic [7:0] exp_l;
    r_up = $urandom_range(1, 30);
    w = 4 + REARM_CYCLES;
    e_set = (((r_up + 2) > w) ? (r_up + 2) : w) + 1;
    run_e = e_set + SETTLE_CYCLES;
    if (kind != 1) pll_lock = 1'b0;
    if (kind != 0) pll_lock_stdy = 1'b0;
    if (exp_loss < 255) exp_loss++;
    exp_q.push_back(exp_loss[7:0]);
    for (int j = 1; j <= run_e; j++) begin
      @(negedge clk);
      n_tests++;
      if (dut_rst !== (j < 3 || j >= run_e)) begin
        n_fail++;
        $display("FAIL loss_dut_rst kind=%0d step=%0d: got %b expected %b", kind, j, dut_rst, (j < 3 || j >= run_e));
      end
      n_tests++;
      if (lock_stdy_rst !== (j >= 4 && j <= 3 + REARM_CYCLES)) begin
        n_fail++;
        $display("FAIL loss_lock_stdy_rst kind=%0d step=%0d: got %b expected %b",
                 kind, j, lock_stdy_rst, (j >= 4 && j <= 3 + REARM_CYCLES));
      end
      if (j == 3) begin
        exp_l = exp_q.pop_front();
        n_tests++;
        if ({state, loss_cnt, retry_cnt} !== {3'd5, exp_l, 2'd0}) begin
          n_fail++;
          $display("FAIL loss_counters kind=%0d: got state=%0d loss=%0d retry=%0d expected state=5 loss=%0d retry=0",
                   kind, state, loss_cnt, retry_cnt, exp_l);
        end
      end
      if (j == r_up) begin pll_lock = 1'b1; pll_lock_stdy = 1'b1; end
    end
    n_tests++;
    if ({run, state} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL loss_relock kind=%0d: got run=%b state=%0d expected run=1 state=4", kind, run, state);
    end
  endtask

  // Reset asserted mid-SETTLE with the clock stopped, then a normal bring-up.
  task automatic test_async_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 10) begin pll_lock = 1'b1; pll_lock_stdy = 1'b1; end
    end
    n_tests++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL async_pre_state: got %0d expected 3", state);
    end
    clk_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if ({lock_stdy_rst, dut_rst, run, fault, retry_cnt, loss_cnt, state, led} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {lock_stdy_rst, dut_rst, run, fault, retry_cnt, loss_cnt, state, led});
    end
    pll_lock = 1'b0; pll_lock_stdy = 1'b0;
    #20 clk_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_loss = 0;
    exp_q.delete();
    rst = 1'b1;
    test_bringup(20);
  endtask

  // 300 loss/relock events: loss_cnt saturates, LED slow in RUN, dark in REARM.
  task automatic test_saturation();
    int kind, r_up;
    bit done;
    logic [7:0] exp_l;
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 2);
      r_up = $urandom_range(1, 6);
      if (kind != 1) pll_lock = 1'b0;
      if (kind != 0) pll_lock_stdy = 1'b0;
      if (exp_loss < 255) exp_loss++;
      exp_q.push_back(exp_loss[7:0]);
      done = 0;
      for (int j = 1; j <= 80 && !done; j++) begin
        @(negedge clk);
        if (j == 5) begin
          n_tests++;
          if ({state, led} !== {3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_rearm_led it=%0d: got state=%0d led=%b expected state=1 led=0", it, state, led);
          end
        end
        if (j > 5 && dut_rst === 1'b1) begin
          done = 1;
          exp_l = exp_q.pop_front();
          n_tests++;
          if (loss_cnt !== exp_l) begin
            n_fail++;
            $display("FAIL sat_loss_cnt it=%0d: got %0d expected %0d", it, loss_cnt, exp_l);
          end
        end
        if (j == r_up) begin pll_lock = 1'b1; pll_lock_stdy = 1'b1; end
      end
      if (!done) begin
        n_tests++;
        n_fail++;
        $display("FAIL sat_relock_timeout it=%0d: got no RUN within 80 cycles expected RUN", it);
      end
      if ((it % 60) == 59) begin
        for (int h = 0; h < 140; h++) begin
          @(negedge clk);
          n_tests++;
          if ({dut_rst, led} !== {1'b1, cyc[BLINK_DIV-1]}) begin
            n_fail++;
            $display("FAIL sat_run_led it=%0d h=%0d: got dut_rst=%b led=%b expected 1 %b",
                     it, h, dut_rst, led, cyc[BLINK_DIV-1]);
          end
        end
      end
    end
    n_tests++;
    if (loss_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final_loss_cnt: got %0d expected 255", loss_cnt);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_tests = 0; n_fail = 0; exp_loss = 0;
    clk = 1'b0; clk_en = 1'b1;
    rst = 1'b0; pll_lock = 1'b0; pll_lock_stdy = 1'b0;

    do_reset(); test_bringup(20);
    do_reset(); test_no_lock();
    do_reset(); test_bringup(52);     // lock on the timeout cycle of attempt 0
    do_reset(); test_bringup(160);    // lock on the would-be fault cycle
    for (int n = 0; n < 4; n++) begin
      do_reset(); test_bringup($urandom_range(1, 160));
    end
    do_reset(); test_settle_glitch(4);
    for (int n = 0; n < 3; n++) begin
      do_reset(); test_settle_glitch($urandom_range(0, 5));
    end
    do_reset(); test_bringup(70);     // one retry before lock
    test_lock_loss(0);
    test_lock_loss(1);
    test_lock_loss($urandom_range(0, 2));
    do_reset(); test_async_reset();
    do_reset(); test_bringup(20); test_saturation();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
